// File: rtl/key_ctrl_if.sv
// Pushbutton, switch and launch-handshake bundle between key_ctrl and its surroundings.
interface key_ctrl_if;
    logic [3:0]  key_n;
    logic [9:0]  sw;
    logic        done;
    logic        go;
    logic [31:0] start;
    logic [7:0]  offset;
    logic        busy;

    modport master (input key_n, sw, done, output go, start, offset, busy);
    modport slave  (output key_n, sw, done, input go, start, offset, busy);
endinterface

// File: rtl/key_ctrl.sv
// Debounced pushbutton front end: offset adjust with auto-repeat, and a
// launch/wait handshake toward the range engine.
module key_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic       clk,
    input  logic       reset,
    key_ctrl_if.master bus
);
    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RP_W   = $clog2(RP_MAX + 1);
    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] RP_DELAY = RP_W'(REPEAT_DELAY);
    localparam logic [RP_W-1:0] RP_STEP  = RP_W'(REPEAT_PERIOD);
    localparam logic [RP_W-1:0] RP_ONE   = RP_W'(1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;

    state_t          state, state_nxt;
    logic [3:0]      sync1, sync2, key_lvl, db, db_d, press;
    logic [DB_W-1:0] db_cnt [4];
    logic [RP_W-1:0] rep_cnt [2];
    logic [1:0]      rep_on, step;
    logic            inc_ev, dec_ev;
    logic [7:0]      offset_q;
    logic [31:0]     start_q;
    logic            go_o, busy_o;

    assign key_lvl = ~sync2;
    assign press   = db & ~db_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            db_d  <= '0;
            for (int unsigned i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= bus.key_n;
            sync2 <= sync1;
            db_d  <= db;
            for (int unsigned i = 0; i < 4; i++) begin
                if (key_lvl[i] != db[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        db[i]     <= key_lvl[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // rep_cnt equals the hold cycle index minus one until the first repeat,
    // then restarts at 1 so each later step lands REPEAT_PERIOD cycles apart.
    always_comb begin
        step = '0;
        for (int unsigned i = 0; i < 2; i++)
            step[i] = db[i] & (rep_on[i] ? (rep_cnt[i] == RP_STEP) : (rep_cnt[i] == RP_DELAY));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rep_on <= '0;
            for (int unsigned i = 0; i < 2; i++) rep_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (!db[i]) begin
                    rep_cnt[i] <= '0;
                    rep_on[i]  <= 1'b0;
                end else if (step[i]) begin
                    rep_cnt[i] <= RP_ONE;
                    rep_on[i]  <= 1'b1;
                end else begin
                    rep_cnt[i] <= rep_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign inc_ev = press[0] | step[0];
    assign dec_ev = press[1] | step[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            offset_q <= '0;
        end else if (press[2]) begin
            offset_q <= '0;
        end else if (inc_ev) begin
            if (offset_q != 8'hFF) offset_q <= offset_q + 8'd1;
        end else if (dec_ev) begin
            if (offset_q != 8'h00) offset_q <= offset_q - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (press[3]) state_nxt = LAUNCH;
            LAUNCH:  state_nxt = WAIT;
            WAIT:    if (bus.done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        go_o   = (state == LAUNCH);
        busy_o = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset)                      start_q <= '0;
        else if (state == IDLE && press[3]) start_q <= {22'b0, bus.sw};
    end

    assign bus.go     = go_o;
    assign bus.busy   = busy_o;
    assign bus.start  = start_q;
    assign bus.offset = offset_q;
endmodule
